// File: rtl/pipe_fwd_if.sv
// Instruction, register-load and memory read-back bundle for pipe_fwd.
// The host/bench side uses the master modport; the pipeline uses the slave modport.
interface pipe_fwd_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 16,
    parameter int MEMD  = 256
);
    localparam int RA = $clog2(NREG);
    localparam int AW = $clog2(MEMD);

    logic             in_valid;
    logic [RA-1:0]    rs1;
    logic [RA-1:0]    rs2;
    logic [RA-1:0]    rd;
    logic [2:0]       func;
    logic [AW-1:0]    addr;
    logic             ld_en;
    logic [RA-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] z;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, rs1, rs2, rd, func, addr,
        output ld_en, ld_addr, ld_data, mem_raddr,
        input  mem_rdata, z, out_valid, busy
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, func, addr,
        input  ld_en, ld_addr, ld_data, mem_raddr,
        output mem_rdata, z, out_valid, busy
    );
endinterface

// File: rtl/pipe_fwd.sv
// Four-stage register/ALU/memory pipeline with full operand forwarding from S1 and S2.
// Results land in the register bank two edges after issue and in data memory one edge later.
module pipe_fwd #(
    parameter int WIDTH = 16,
    parameter int NREG  = 16,
    parameter int MEMD  = 256
) (
    input  logic       clk1,
    input  logic       rst_n,
    pipe_fwd_if.slave  bus
);
    localparam int RA = $clog2(NREG);
    localparam int AW = $clog2(MEMD);

    function automatic logic [WIDTH-1:0] alu(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (f)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a * b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return -a;
            default: return a >> 1;
        endcase
    endfunction

    logic [WIDTH-1:0] regbank [NREG];
    logic [WIDTH-1:0] mem     [MEMD];

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [RA-1:0]    s1_rd;
    logic [2:0]       s1_func;
    logic [AW-1:0]    s1_addr;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_z;
    logic [RA-1:0]    s2_rd;
    logic [AW-1:0]    s2_addr;

    logic             s3_valid;
    logic [WIDTH-1:0] s3_z;
    logic [AW-1:0]    s3_addr;

    logic [WIDTH-1:0] s1_alu;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy_i;
    logic             ld_ok;

    assign s1_alu = alu(s1_func, s1_a, s1_b);
    assign busy_i = s1_valid | s2_valid | s3_valid;
    assign ld_ok  = bus.ld_en & ~busy_i & ~bus.in_valid;
    assign bus.busy = busy_i;

    // Youngest producer wins: S1's live ALU result, then S2's latched result, then the bank.
    always_comb begin
        opa = regbank[bus.rs1];
        opb = regbank[bus.rs2];
        if (s1_valid && s1_rd == bus.rs1)
            opa = s1_alu;
        else if (s2_valid && s2_rd == bus.rs1)
            opa = s2_z;
        if (s1_valid && s1_rd == bus.rs2)
            opb = s1_alu;
        else if (s2_valid && s2_rd == bus.rs2)
            opb = s2_z;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rd    <= '0;
            s1_func  <= '0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_z     <= '0;
            s2_rd    <= '0;
            s2_addr  <= '0;
            s3_valid <= 1'b0;
            s3_z     <= '0;
            s3_addr  <= '0;
            bus.z         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_a     <= opa;
            s1_b     <= opb;
            s1_rd    <= bus.rd;
            s1_func  <= bus.func;
            s1_addr  <= bus.addr;
            s2_valid <= s1_valid;
            s2_z     <= s1_alu;
            s2_rd    <= s1_rd;
            s2_addr  <= s1_addr;
            s3_valid <= s2_valid;
            s3_z     <= s2_z;
            s3_addr  <= s2_addr;
            bus.z         <= s3_z;
            bus.out_valid <= s3_valid;
        end
    end

    // A pipeline write and an accepted load never coincide: a valid S2 keeps busy high.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regbank[i] <= '0;
        end else if (s2_valid) begin
            regbank[s2_rd] <= s2_z;
        end else if (ld_ok) begin
            regbank[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Memory contents survive reset; only the read-back register is cleared.
    always_ff @(posedge clk1) begin
        if (s3_valid)
            mem[s3_addr] <= s3_z;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            bus.mem_rdata <= '0;
        else
            bus.mem_rdata <= mem[bus.mem_raddr];
    end
endmodule

// File: tb/tb_pipe_fwd.sv
// Directed bench for pipe_fwd: independent stream, forwarding hazards, wrap,
// load arbitration, bubbles and mid-flight reset, all against hand-computed values.
module tb_pipe_fwd;
    logic clk1 = 1'b0;
    logic rst_n = 1'b0;

    pipe_fwd_if #(.WIDTH(16), .NREG(16), .MEMD(256)) bus ();

    pipe_fwd #(.WIDTH(16), .NREG(16), .MEMD(256)) u_dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        v;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [2:0]  f;
        logic [7:0]  addr;
        logic [15:0] exp;
    } instr_t;

    instr_t prog [8];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic setp(input int i, input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] rd, input logic [2:0] f, input logic [7:0] addr,
                        input logic [15:0] exp);
        prog[i].v    = v;
        prog[i].rs1  = rs1;
        prog[i].rs2  = rs2;
        prog[i].rd   = rd;
        prog[i].f    = f;
        prog[i].addr = addr;
        prog[i].exp  = exp;
    endtask

    task automatic drive_bubble();
        bus.in_valid = 1'b0;
    endtask

    // Issue prog[0..n-1] on consecutive edges; result of slot c appears after edge c+3.
    task automatic run(input string tag, input int n);
        for (int c = 0; c < n + 3; c++) begin
            if (c < n) begin
                bus.in_valid = prog[c].v;
                bus.rs1      = prog[c].rs1;
                bus.rs2      = prog[c].rs2;
                bus.rd       = prog[c].rd;
                bus.func     = prog[c].f;
                bus.addr     = prog[c].addr;
            end else begin
                drive_bubble();
            end
            step();
            if (c >= 3) begin
                chk({tag, "_vld"}, 32'(bus.out_valid), 32'(prog[c-3].v));
                if (prog[c-3].v)
                    chk({tag, "_z"}, 32'(bus.z), 32'(prog[c-3].exp));
            end else begin
                chk({tag, "_vld_pre"}, 32'(bus.out_valid), 32'd0);
            end
        end
        drive_bubble();
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        step();
        bus.ld_en   = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++)
            load(4'(i), 16'(i));
    endtask

    task automatic mem_rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
        bus.mem_raddr = a;
        step();
        chk(tag, 32'(bus.mem_rdata), 32'(exp));
    endtask

    // Observe a register through an OR with itself into scratch r15 / mem[255].
    task automatic readreg(input string tag, input logic [3:0] r, input logic [15:0] exp);
        setp(0, 1'b1, r, r, 4'd15, 3'b100, 8'd255, exp);
        run(tag, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd        = '0;
        bus.func      = '0;
        bus.addr      = '0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.mem_raddr = '0;
        #12;
        chk("rst_z", 32'(bus.z), 32'd0);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdata", 32'(bus.mem_rdata), 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
        step();
        readreg("rst_r3", 4'd3, 16'h0000);

        // Independent stream
        load_all();
        setp(0, 1, 4'd5, 4'd3, 4'd1, 3'b000, 8'd125, 16'd8);
        setp(1, 1, 4'd6, 4'd4, 4'd2, 3'b001, 8'd126, 16'd2);
        setp(2, 1, 4'd7, 4'd5, 4'd3, 3'b000, 8'd127, 16'd12);
        setp(3, 1, 4'd8, 4'd6, 4'd4, 3'b001, 8'd128, 16'd2);
        setp(4, 1, 4'd9, 4'd7, 4'd5, 3'b000, 8'd129, 16'd16);
        run("indep", 5);
        mem_rd("indep_m125", 8'd125, 16'd8);
        mem_rd("indep_m126", 8'd126, 16'd2);
        mem_rd("indep_m127", 8'd127, 16'd12);
        mem_rd("indep_m128", 8'd128, 16'd2);
        mem_rd("indep_m129", 8'd129, 16'd16);

        // Hazard forwarding
        load_all();
        setp(0, 1, 4'd5, 4'd3, 4'd1, 3'b000, 8'd10, 16'd8);
        setp(1, 1, 4'd1, 4'd4, 4'd2, 3'b001, 8'd11, 16'd4);
        setp(2, 1, 4'd1, 4'd2, 4'd6, 3'b000, 8'd12, 16'd12);
        run("haz", 3);
        readreg("haz_r6", 4'd6, 16'd12);
        readreg("haz_r2", 4'd2, 16'd4);

        // Arithmetic wrap
        load(4'd1, 16'hFFFF);
        load(4'd2, 16'h0001);
        setp(0, 1, 4'd1, 4'd2, 4'd8,  3'b000, 8'd130, 16'h0000);
        setp(1, 1, 4'd2, 4'd1, 4'd9,  3'b001, 8'd131, 16'h0002);
        setp(2, 1, 4'd1, 4'd1, 4'd10, 3'b010, 8'd132, 16'h0001);
        setp(3, 1, 4'd2, 4'd2, 4'd11, 3'b110, 8'd133, 16'hFFFF);
        setp(4, 1, 4'd1, 4'd2, 4'd12, 3'b111, 8'd134, 16'h7FFF);
        run("wrap", 5);
        setp(0, 1, 4'd1, 4'd2, 4'd13, 3'b011, 8'd135, 16'h0001);
        setp(1, 1, 4'd1, 4'd2, 4'd13, 3'b100, 8'd135, 16'hFFFF);
        setp(2, 1, 4'd1, 4'd2, 4'd13, 3'b101, 8'd135, 16'hFFFE);
        run("logic", 3);

        // Load arbitration: r9 holds 2 from the wrap test
        bus.in_valid = 1'b1;
        bus.rs1 = 4'd1; bus.rs2 = 4'd2; bus.rd = 4'd13; bus.func = 3'b011; bus.addr = 8'd140;
        step();
        drive_bubble();
        chk("arb_busy1", 32'(bus.busy), 32'd1);
        bus.ld_en = 1'b1; bus.ld_addr = 4'd9; bus.ld_data = 16'h1234;
        step();
        chk("arb_busy2", 32'(bus.busy), 32'd1);
        step();
        bus.ld_en = 1'b0;
        step();
        step();
        chk("arb_idle", 32'(bus.busy), 32'd0);
        readreg("arb_drop", 4'd9, 16'h0002);
        load(4'd9, 16'h1234);
        readreg("arb_take", 4'd9, 16'h1234);

        // Bubbles interleaved
        load_all();
        readreg("bub_pre_r10", 4'd10, 16'd10);
        setp(0, 1, 4'd10, 4'd10, 4'd10, 3'b100, 8'd60, 16'd10);
        run("bub_seed", 1);
        setp(0, 1, 4'd1, 4'd2, 4'd11, 3'b000, 8'd61, 16'd3);
        setp(1, 0, 4'd1, 4'd2, 4'd10, 3'b000, 8'd60, 16'd3);
        setp(2, 1, 4'd3, 4'd4, 4'd12, 3'b000, 8'd62, 16'd7);
        setp(3, 0, 4'd3, 4'd4, 4'd10, 3'b000, 8'd60, 16'd7);
        run("bub", 4);
        mem_rd("bub_m60", 8'd60, 16'd10);
        mem_rd("bub_m61", 8'd61, 16'd3);
        mem_rd("bub_m62", 8'd62, 16'd7);
        readreg("bub_r10", 4'd10, 16'd10);

        // Reset mid-operation
        setp(0, 1, 4'd5, 4'd6, 4'd13, 3'b000, 8'd50, 16'd11);
        run("rst_seed", 1);
        mem_rd("rst_m50_pre", 8'd50, 16'd11);
        bus.in_valid = 1'b1;
        bus.rs1 = 4'd1; bus.rs2 = 4'd2; bus.rd = 4'd14; bus.func = 3'b000; bus.addr = 8'd70;
        step();
        bus.rs1 = 4'd3; bus.rs2 = 4'd4; bus.addr = 8'd71;
        step();
        bus.rs1 = 4'd5; bus.rs2 = 4'd6; bus.rd = 4'd7; bus.func = 3'b101; bus.addr = 8'd50;
        step();
        drive_bubble();
        step();
        chk("rst_pre_vld", 32'(bus.out_valid), 32'd1);
        chk("rst_pre_z", 32'(bus.z), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_z", 32'(bus.z), 32'd0);
        chk("rst_mid_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        step();
        @(negedge clk1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_no_pulse", 32'(bus.out_valid), 32'd0);
        end
        mem_rd("rst_m50_kept", 8'd50, 16'd11);
        readreg("rst_r7", 4'd7, 16'd0);
        readreg("rst_r13", 4'd13, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_fwd.md
# pipe_fwd

Parametrised single-clock successor of the four-stage register/ALU/memory pipeline. It accepts one register-to-register ALU instruction per cycle and writes the result both to a register bank and to a data memory. Full operand forwarding removes read-after-write hazards without stalls. A register load port and a memory read-back port let the bench and host initialise and inspect state without hierarchical access.

## Interface
- WIDTH, 16, datapath and register width
- NREG, 16, register count (power of 2); RA = clog2(NREG)
- MEMD, 256, data memory depth (power of 2); AW = clog2(MEMD)
- clk1  in  1  sole clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present this cycle
- rs1, rs2  in  RA  source register indices
- rd  in  RA  destination register
- func  in  3  opcode
- addr  in  AW  memory write address
- ld_en  in  1  register load request
- ld_addr  in  RA  register to load
- ld_data  in  WIDTH  load value
- mem_raddr  in  AW  memory read-back address
- mem_rdata  out  WIDTH  registered read-back data
- z  out  WIDTH  result of instruction leaving stage 4
- out_valid  out  1  z valid this cycle
- busy  out  1  any of S1–S3 holds a valid instruction

## Operation
- func encodings:
  - 000 A+B
  - 001 A−B
  - 010 low WIDTH bits of A*B
  - 011 A&B
  - 100 A|B
  - 101 A^B
  - 110 −A
  - 111 A>>1 (logical)
- Add, subtract and negate wrap modulo 2^WIDTH.
- S1 (issue edge): read operands A and B with forwarding; latch A, B, rd, func, addr and the valid bit.
- S2: latch z2 = ALU(S1), together with rd, addr and valid.
- S3: regbank[rd] ← z2 when valid; latch z3, addr and valid.
- S4: mem[addr] ← z3 when valid; z ← z3; out_valid ← S3 valid.
- Forwarding, applied per operand, highest priority first:
  - live ALU output of a valid S1 with matching rd;
  - z2 of a valid S2 with matching rd;
  - regbank.
- Register-load port:
  - ld_en is honoured only when busy = 0 and in_valid = 0; otherwise it is silently dropped.
  - An accepted load writes regbank[ld_addr] at the edge.
- mem_rdata ← mem[mem_raddr] on every edge. If the same edge writes that address, the read returns the old data.
- Bubbles (in_valid = 0) travel the pipe as valid = 0 and perform no register or memory write.
- Reset (asynchronous, at any time, including mid-operation):
  - all stage valid bits clear; z = 0, out_valid = 0, mem_rdata = 0, busy = 0;
  - all regbank entries = 0;
  - in-flight instructions are discarded with no writes;
  - memory contents are not reset and are retained.

## Timing
- An instruction sampled at edge k:
  - enters S1 at k;
  - reaches S2 at k+1;
  - writes regbank at k+2;
  - writes memory and drives z/out_valid at k+3.
- z and out_valid remain valid for exactly one cycle per instruction.
- Throughput is 1 instruction per cycle. There are no stalls and no backpressure.
- A dependent instruction may issue in the very next cycle, and its result equals the serial-execution result.
- If rd written at S3 equals the target of a same-edge accepted load, the load cannot be accepted (busy = 1), so no conflict arises.
- The memory read-back latency is 1 cycle.
- Memory written at edge k+3 is visible on mem_rdata after edge k+4.

## Test plan
- Independent instruction stream:
  - Setup: load r[i] = i for every i. Then issue back-to-back:
    - (5+3 → r1, addr 125)
    - (6−4 → r2, addr 126)
    - (7+5 → r3, addr 127)
    - (8−6 → r4, addr 128)
    - (9+7 → r5, addr 129)
  - Required response: z = 8, 2, 12, 2, 16 on consecutive cycles, starting 3 edges after the first issue.
  - Read-back of mem[125..129] returns the same values.
- Hazard forwarding:
  - Stimulus, after loads r[i] = i, issued consecutively:
    - r1 = r5+r3
    - r2 = r1−r4
    - r6 = r1+r2
  - Required response: z = 8, 4, 12.
  - These results exercise both the S1 and the S2 forwarding paths.
- Arithmetic wrap:
  - Stimulus: r1 = 0xFFFF, r2 = 1; issue add, sub (r2−r1), mul (r1*r1), negate (−r2), shr (r1>>1).
  - Required response: z = 0x0000, 0x0002, 0x0001, 0xFFFF, 0x7FFF.
- Load arbitration:
  - Stimulus: assert ld_en while an instruction is in S2.
  - Required response: the register is unchanged, the load is dropped, and a later read returns the old value.
  - Stimulus: assert ld_en when the pipe is idle.
  - Required response: the load is taken.
- Reset mid-operation:
  - Stimulus: drop rst_n between edges k+1 and k+2 of an instruction targeting r7 and addr 50.
  - Required response: z = 0 and out_valid = 0 immediately; no out_valid pulse follows; r7 reads 0; mem[50] is unchanged.
- Bubbles interleaved:
  - Stimulus: in_valid pattern 1,0,1,0.
  - Required response: out_valid shows the same pattern delayed by 3 edges, and bubble slots write neither regbank nor memory.
